// File: rtl/weight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_pkg
//  Description : Shared defaults, FSM state encoding and lane-slice helper
//                for the weight loader and its shadow buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package weight_pkg;

    // Default geometry of one weight vector
    localparam int unsigned DEF_WEIGHT_BW = 8;
    localparam int unsigned DEF_NUM_LANES = 4;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Low bit position of a lane inside the flat weight bus
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bw);
        return lane * bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_shadow_buf.sv
`default_nettype none
// ============================================================================
//  Module      : weight_shadow_buf
//  Description : NUM_LANES x WEIGHT_BW register file. One lane is written per
//                cycle; all lanes are exposed together on a flat bus.
//  Revision    : 1.0  initial release
// ============================================================================
module weight_shadow_buf
    import weight_pkg::*;
#(
    parameter int unsigned WEIGHT_BW = DEF_WEIGHT_BW,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned CNT_BW    = $clog2(DEF_NUM_LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_we,
    input  logic [CNT_BW-1:0]              i_lane,
    input  logic [WEIGHT_BW-1:0]           i_wdata,
    output logic [NUM_LANES*WEIGHT_BW-1:0] o_bus
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [WEIGHT_BW-1:0] r_q;
        logic                 w_sel;

        assign w_sel = i_we && (i_lane == CNT_BW'(g));

        // Lane register: captures the incoming weight when this lane is addressed
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_sel) begin
                r_q <= i_wdata;
            end
        end

        assign o_bus[lane_lsb(g, WEIGHT_BW) +: WEIGHT_BW] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Collects a serial stream of signed weights into a shadow
//                buffer and, once full and the MAC array is idle, strobes a
//                single reload so every lane register updates together.
//  Revision    : 1.0  initial release
// ============================================================================
module weight_loader
    import weight_pkg::*;
#(
    parameter int unsigned WEIGHT_BW = DEF_WEIGHT_BW,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [WEIGHT_BW-1:0]           w_data,
    input  logic                           w_last,
    input  logic                           array_busy,
    output logic                           weight_reload,
    output logic [NUM_LANES*WEIGHT_BW-1:0] weight_bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned       CNT_BW      = $clog2(NUM_LANES);
    localparam logic [CNT_BW-1:0] c_LAST_LANE = CNT_BW'(NUM_LANES - 1);

    state_t            r_state;
    logic [CNT_BW-1:0] r_cnt;
    logic              r_w_ready;
    logic              r_reload;
    logic              r_done;
    logic              r_busy;
    logic              r_err;

    logic              w_beat;
    logic              w_final_beat;

    // w_ready is high exactly while in FILL, so a beat can only land there
    assign w_beat       = w_valid && r_w_ready;
    assign w_final_beat = (r_cnt == c_LAST_LANE);

    // Controller: state, lane counter, framing check and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_w_ready <= 1'b0;
            r_reload  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_reload <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_FILL;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_w_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        if (w_final_beat) begin
                            // Lane count decides the end of the vector; a
                            // missing w_last is only flagged
                            r_state   <= ST_WAIT;
                            r_cnt     <= '0;
                            r_w_ready <= 1'b0;
                            if (!w_last) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_BW'(1);
                            if (w_last) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // Hold the new vector back while the array is computing
                    if (!array_busy) begin
                        r_state  <= ST_COMMIT;
                        r_reload <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_w_ready <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    weight_shadow_buf #(
        .WEIGHT_BW (WEIGHT_BW),
        .NUM_LANES (NUM_LANES),
        .CNT_BW    (CNT_BW)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_beat),
        .i_lane  (r_cnt),
        .i_wdata (w_data),
        .o_bus   (weight_bus)
    );

    assign w_ready       = r_w_ready;
    assign weight_reload = r_reload;
    assign done          = r_done;
    assign busy          = r_busy;
    assign err           = r_err;

endmodule
`default_nettype wire
